// File: rtl/div_seq_flag.sv
// Iterative restoring unsigned divider, one quotient bit per clock, with
// divide-by-zero detection, a per-result error flag and a sticky error flag.
module div_seq_flag #(
    parameter int         WIDTH  = 8,
    parameter logic [2:0] OP_DIV = 3'b011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             err_clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             err,
    output logic             err_sticky
);

    // state | meaning
    // IDLE  | waiting for start with sel==OP_DIV
    // RUN   | shifting/subtracting one quotient bit per cycle
    // DONE  | one-cycle done pulse, results valid
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;

    logic             accept;
    logic             sticky_set;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    assign accept = (state_q == IDLE) && start && (sel == OP_DIV);

    // Extra top bit of trial acts as the borrow: set means the subtraction went negative.
    assign trial    = {r_q, q_q[WIDTH-1]} - {2'b00, div_q};
    assign trial_ok = ~trial[WIDTH+1];
    assign r_sh     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign r_next   = trial_ok ? trial[WIDTH:0] : r_sh;
    assign q_next   = {q_q[WIDTH-2:0], trial_ok};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        q_d        = q_q;
        div_d      = div_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        err_d      = err_q;
        sticky_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (divisor == '0) begin
                        quot_d     = '1;
                        rem_d      = dividend;
                        err_d      = 1'b1;
                        sticky_set = 1'b1;
                        state_d    = DONE;
                    end else begin
                        r_d     = '0;
                        q_d     = dividend;
                        div_d   = divisor;
                        cnt_d   = CW'(WIDTH);
                        err_d   = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = q_next;
                    rem_d   = r_next[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new divide-by-zero outranks a simultaneous clear.
        if (sticky_set) begin
            sticky_d = 1'b1;
        end else if (err_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            r_q      <= '0;
            q_q      <= '0;
            div_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            q_q      <= q_d;
            div_q    <= div_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign quotient   = quot_q;
    assign remainder  = rem_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;

endmodule
